// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 stream encryptor: controller state
// encoding, S-box geometry and the key-byte selection helper.
package rc4_pkg;

  localparam int S_SIZE            = 256;
  localparam int KEY_BYTES_DEFAULT = 3;
  localparam int KEY_BYTES_MAX     = 32;
  localparam int KEY_MAX_BITS      = 8 * KEY_BYTES_MAX;
  localparam int INIT_CYCLES       = S_SIZE;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_RD_I,
    ST_KSA_W_I,
    ST_KSA_J,
    ST_KSA_RD_J,
    ST_KSA_W_J,
    ST_KSA_WR_I,
    ST_KSA_WR_J,
    ST_KSA_NEXT,
    ST_PG_INC,
    ST_PG_RD_I,
    ST_PG_W_I,
    ST_PG_J,
    ST_PG_RD_J,
    ST_PG_W_J,
    ST_PG_WR_I,
    ST_PG_WR_J,
    ST_PG_RD_F,
    ST_PG_W_F,
    ST_PG_IN,
    ST_PG_OUT,
    ST_DONE
  } rc4_state_e;

  // Key byte idx of an nBytes-long key, most significant byte is index 0.
  // The key is passed zero-extended to the widest supported key.
  function automatic logic [7:0] key_byte(input logic [KEY_MAX_BITS-1:0] key,
                                          input int nBytes,
                                          input int idx);
    logic [KEY_MAX_BITS-1:0] shifted;
    shifted = key >> (8 * (nBytes - 1 - idx));
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/rc4_stream_encryptor_if.sv
// Plaintext-in / ciphertext-out valid/ready stream pair of the encryptor.
// The slave side is the encryptor, the master side is whoever feeds and
// drains it.
interface rc4_stream_encryptor_if;

  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_ready;

  modport master (
    output pt_data, pt_valid, ct_ready,
    input  pt_ready, ct_data, ct_valid
  );

  modport slave (
    input  pt_data, pt_valid, ct_ready,
    output pt_ready, ct_data, ct_valid
  );

endinterface

// File: rtl/rc4_sbox_ram.sv
// 256x8 single-port S-box memory. The read address is registered and the
// read data is registered again, so read data appears two cycles after the
// address is presented. A write lands on the edge where wren_i is high.
module rc4_sbox_ram
  import rc4_pkg::*;
(
  input  logic       clk_i,
  input  logic [7:0] address_i,
  input  logic [7:0] data_i,
  input  logic       wren_i,
  output logic [7:0] q_o
);

  logic [7:0] mem [S_SIZE];
  logic [7:0] addr_q;

  // Write port, address register and output register of the memory.
  always_ff @(posedge clk_i) begin
    if (wren_i) begin
      mem[address_i] <= data_i;
    end
    addr_q <= address_i;
    q_o    <= mem[addr_q];
  end

endmodule

// File: rtl/rc4_stream_encryptor.sv
// RC4 encryptor: fills the S-box with the identity permutation, runs the
// key-scheduling pass, then produces one keystream byte per plaintext byte
// and emits plaintext XOR keystream. One byte is in flight at a time.
module rc4_stream_encryptor
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int LEN_W     = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [LEN_W-1:0]       msg_len,
  rc4_stream_encryptor_if.slave  stream,
  output logic                   busy,
  output logic                   done
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  rc4_state_e             state_q, state_d;
  logic [7:0]             i_q, i_d, j_q, j_d;
  logic [7:0]             si_q, si_d, sj_q, sj_d;
  logic [7:0]             ctData_q, ctData_d;
  logic [LEN_W-1:0]       k_q, k_d, msgLen_q, msgLen_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;

  logic [7:0] ramAddr, ramData, ramQ, keyByte;
  logic       ramWren;

  rc4_sbox_ram u_sbox (
    .clk_i     (CLOCK_50),
    .address_i (ramAddr),
    .data_i    (ramData),
    .wren_i    (ramWren),
    .q_o       (ramQ)
  );

  assign keyByte = key_byte(KEY_MAX_BITS'(key_q), KEY_BYTES, int'(kidx_q));

  assign stream.pt_ready = (state_q == ST_PG_IN);
  assign stream.ct_valid = (state_q == ST_PG_OUT);
  assign stream.ct_data  = ctData_q;
  assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done            = (state_q == ST_DONE);

  // Controller and datapath registers; reset parks everything in IDLE.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      kidx_q   <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      ctData_q <= '0;
      key_q    <= '0;
      msgLen_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      kidx_q   <= kidx_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      ctData_q <= ctData_d;
      key_q    <= key_d;
      msgLen_q <= msgLen_d;
    end
  end

  // Next-state, S-box port control and register updates for every phase.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    kidx_d   = kidx_q;
    si_d     = si_q;
    sj_d     = sj_q;
    ctData_d = ctData_q;
    key_d    = key_q;
    msgLen_d = msgLen_q;
    ramAddr  = i_q;
    ramData  = i_q;
    ramWren  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          key_d    = secret_key;
          msgLen_d = msg_len;
          i_d      = '0;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        ramWren = 1'b1;
        i_d     = i_q + 8'd1;
        if (i_q == 8'(INIT_CYCLES - 1)) begin
          j_d     = '0;
          kidx_d  = '0;
          state_d = ST_KSA_RD_I;
        end
      end
      ST_KSA_RD_I: state_d = ST_KSA_W_I;
      ST_KSA_W_I:  state_d = ST_KSA_J;
      ST_KSA_J: begin
        si_d    = ramQ;
        j_d     = j_q + ramQ + keyByte;
        state_d = ST_KSA_RD_J;
      end
      ST_KSA_RD_J: begin
        ramAddr = j_q;
        state_d = ST_KSA_W_J;
      end
      ST_KSA_W_J: begin
        ramAddr = j_q;
        state_d = ST_KSA_WR_I;
      end
      ST_KSA_WR_I: begin
        ramWren = 1'b1;
        ramData = ramQ;
        sj_d    = ramQ;
        state_d = ST_KSA_WR_J;
      end
      ST_KSA_WR_J: begin
        ramWren = 1'b1;
        ramAddr = j_q;
        ramData = si_q;
        state_d = ST_KSA_NEXT;
      end
      ST_KSA_NEXT: begin
        if (i_q == 8'hFF) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = (msgLen_q == '0) ? ST_DONE : ST_PG_INC;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
          state_d = ST_KSA_RD_I;
        end
      end
      ST_PG_INC: begin
        i_d     = i_q + 8'd1;
        state_d = ST_PG_RD_I;
      end
      ST_PG_RD_I: state_d = ST_PG_W_I;
      ST_PG_W_I:  state_d = ST_PG_J;
      ST_PG_J: begin
        si_d    = ramQ;
        j_d     = j_q + ramQ;
        state_d = ST_PG_RD_J;
      end
      ST_PG_RD_J: begin
        ramAddr = j_q;
        state_d = ST_PG_W_J;
      end
      ST_PG_W_J: begin
        ramAddr = j_q;
        state_d = ST_PG_WR_I;
      end
      ST_PG_WR_I: begin
        ramWren = 1'b1;
        ramData = ramQ;
        sj_d    = ramQ;
        state_d = ST_PG_WR_J;
      end
      ST_PG_WR_J: begin
        ramWren = 1'b1;
        ramAddr = j_q;
        ramData = si_q;
        state_d = ST_PG_RD_F;
      end
      ST_PG_RD_F, ST_PG_W_F: begin
        ramAddr = si_q + sj_q;
        state_d = (state_q == ST_PG_RD_F) ? ST_PG_W_F : ST_PG_IN;
      end
      ST_PG_IN: begin
        ramAddr = si_q + sj_q;
        if (stream.pt_valid) begin
          ctData_d = stream.pt_data ^ ramQ;
          state_d  = ST_PG_OUT;
        end
      end
      ST_PG_OUT: begin
        if (stream.ct_ready) begin
          k_d     = k_q + LEN_W'(1);
          state_d = ((k_q + LEN_W'(1)) == msgLen_q) ? ST_DONE : ST_PG_INC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/rc4_stream_encryptor.md
Name: rc4_stream_encryptor

Overview:
- Encrypt-side counterpart of the RC4 decryption/cracking datapath.
- Given a 24-bit secret key and a byte count, it performs the following in order:
  - initialises the 256-byte S-box;
  - runs the KSA;
  - runs the PRGA, consuming plaintext bytes on a valid/ready stream and emitting ciphertext bytes (plaintext XOR keystream) on a second valid/ready stream.
- Produces the encrypted-message ROM images that the decryption/cracking path consumes, and serves as a bit-exact reference on-chip.

Parameters:
- KEY_BYTES, 3, secret key length in bytes; key byte for index i is taken as i mod KEY_BYTES, MSB byte first.
- LEN_W, 8, width of msg_len; maximum message is 2^LEN_W-1 bytes.

Ports:
- CLOCK_50 input 1: system clock, all state on rising edge.
- reset_n input 1: asynchronous active-low reset.
- start input 1: one-cycle request, sampled only in IDLE.
- secret_key input 8*KEY_BYTES: key; secret_key[23:16] is key byte 0. Sampled on accepted start.
- msg_len input LEN_W: byte count, sampled on accepted start.
- pt_data input 8: plaintext byte.
- pt_valid input 1: pt_data valid.
- pt_ready output 1: block accepts pt_data this cycle.
- ct_data output 8: ciphertext byte.
- ct_valid output 1: ct_data valid.
- ct_ready input 1: downstream accepts ct_data.
- busy output 1: high from the cycle after an accepted start until DONE.
- done output 1: level; high in DONE, cleared by the next accepted start.

Behaviour:
- Reset (async, reset_n=0): FSM returns to IDLE. Outputs pt_ready=0, ct_valid=0, ct_data=0, busy=0, done=0. Counters i, j, k are 0. S-box contents are don't-care; every run re-initialises them.
- S-box: single-port 256x8 synchronous RAM.
  - Read address is registered; q is valid 2 cycles after the address is driven, so every read has a dedicated wait state.
  - Write takes effect at the edge where wren=1.
- FSM states and transitions:
  - IDLE: on start, latch key and msg_len, go to INIT. start outside IDLE is ignored.
  - INIT: write S[c]=c for c=0..255, one write per cycle, 256 cycles. Then go to KSA with i=0, j=0, key index=0.
  - KSA_RD_I → KSA_W_I: si=S[i].
  - KSA_J: j=j+si+key[kidx] (mod 256). kidx is a mod-KEY_BYTES counter, not a divider.
  - KSA_RD_J → KSA_W_J: sj=S[j].
  - KSA_WR_I: S[i]=sj.
  - KSA_WR_J: S[j]=si.
  - If i==255, go to PRGA with i=0, j=0, k=0. Otherwise i++, kidx++ (wrapping), back to KSA_RD_I.
  - PRGA entry: if msg_len==0, go directly to DONE.
  - PG_INC: i=i+1.
  - PG_RD_I → PG_W_I: si=S[i].
  - PG_J: j=j+si.
  - PG_RD_J → PG_W_J: sj=S[j].
  - PG_WR_I: S[i]=sj.
  - PG_WR_J: S[j]=si.
  - PG_RD_F → PG_W_F: f=S[(si+sj) mod 256].
  - PG_IN: pt_ready=1. On pt_valid&pt_ready, ct_data<=pt_data^f and go to PG_OUT.
  - PG_OUT: ct_valid=1, ct_data held stable. On ct_ready, k++. If k+1==msg_len go to DONE, else go to PG_INC.
  - DONE: done=1, busy=0. On start, restart as from IDLE.
- Arithmetic: all index arithmetic is 8-bit modulo 256. i wraps from 255 to 0 in PRGA for messages longer than 255 bytes (LEN_W>8).
- Handshake rules:
  - pt_ready is combinationally 1 only in PG_IN.
  - ct_valid is 1 only in PG_OUT.
  - At most one byte is in flight.
  - A pt_valid with no pt_ready is held by the source; none is dropped.
- Latency:
  - INIT: 256 cycles.
  - KSA: 8 cycles/iteration, 2048 cycles total.
  - PRGA: 12 cycles/byte plus any stall.
- Simultaneous events: start while busy is ignored. Async reset overrides all.
- Reset mid-operation: partial output is abandoned. The next start re-runs INIT/KSA, and output restarts from keystream byte 0.

Decomposition:
- Package rc4_pkg holds:
  - the state enum typedef;
  - S_SIZE=256, KEY_BYTES default, INIT_CYCLES;
  - the function key_byte(key, idx).
- One sub-module, rc4_sbox_ram: the 256x8 single-port S-box wrapper over the vendor RAM, with the same interface as the existing S memory. The FSM and datapath stay in rc4_stream_encryptor.

Test Plan:
- Known-answer test:
  - Stimulus: key=0x4B6579 ("Key"), msg_len=9, plaintext "Plaintext".
  - Required: ct bytes BB F3 16 E8 D9 40 AF 0A D3, then done=1, busy=0.
- Keystream check:
  - Stimulus: same key, msg_len=10, plaintext all 0x00.
  - Required: ct = EB 9F 77 81 B7 34 CA 72 A7 19.
- Backpressure:
  - Stimulus: ct_ready=0 for 5 cycles after the first ct_valid.
  - Required: ct_data stays 0xBB, pt_ready stays 0, sequence unchanged. Separately, deasserting pt_valid for 7 cycles in PG_IN loses no byte.
- Zero-length message:
  - Stimulus: msg_len=0.
  - Required: pt_ready never asserts; done rises exactly 256+2048+O(1) cycles after start.
- Reset mid-operation:
  - Stimulus: drop reset_n after the 3rd ct byte, release it, issue start with the same key.
  - Required: all outputs are 0 during reset, and output restarts at BB F3 16…
- Round-trip and busy start:
  - Stimulus: feed the produced ciphertext back as plaintext with the same key; also assert start while busy.
  - Required: "Plaintext" is recovered, and the busy start has no effect.
